enigma_step_ctrl: RTL
=====================

# enigma_step_ctrl

Command-driven sequencer for the Enigma datapath. It owns the three rotor position registers and the rotor-type selection, and it decodes host commands. On every ENCRYPT it applies the historical stepping rule, including the middle-rotor double-step, then drives the combinational or multi-cycle substitution datapath through a start/done handshake. It sits between the pin-level input decode in `top` and the rotor/reflector path, and returns each enciphered letter with a one-cycle valid strobe.

## Interface
Parameters:
- `N_ROT`, 3, number of rotors; index 0 is the rightmost (fast) rotor.
- `DP_TIMEOUT`, 15, maximum cycles to wait for `dp_done` before aborting.

Ports:
- `clk`  in  1  single system clock.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  high only in IDLE; a command is accepted when `cmd_valid & cmd_ready`.
- `cmd_op`  in  3  opcode: 0 NOP, 1 SET_POS, 2 SET_TYPE, 3 ENCRYPT, 4 CLEAR_POS.
- `cmd_data`  in  5  letter 0..25 (SET_POS, ENCRYPT) or rotor type 0..4 (SET_TYPE).
- `pos`  out  3×5  current rotor positions, packed as {left, mid, right}.
- `rot_type`  out  3×3  selected rotor types, same packing.
- `dp_start`  out  1  one-cycle pulse; `dp_char` and `pos` are stable from this cycle until `dp_done`.
- `dp_char`  out  5  letter presented to the datapath.
- `dp_done`  in  1  datapath result valid.
- `dp_result`  in  5  enciphered letter.
- `out_valid`  out  1  one-cycle strobe.
- `out_char`  out  5  result; holds its value until the next `out_valid`.
- `busy`  out  1  equal to `~cmd_ready`.
- `err`  out  1  sticky error flag; cleared by `rst` or CLEAR_POS.

## Operation
- FSM states: IDLE, STEP, XLATE, WAIT, EMIT.
- SET_POS:
  - Loads `cmd_data` into the rotor selected by the internal load index `li`, then advances `li` as 0→1→2→0.
  - `cmd_data` > 25 sets `err`; the position is unchanged and `li` does not advance.
- SET_TYPE:
  - Same `li` sequencing (a separate index `ti`).
  - `cmd_data` > 4 sets `err` with no change.
- CLEAR_POS: all positions go to 0, `li` and `ti` go to 0, `err` goes to 0. Types are unchanged.
- NOP: accepted and ignored. Opcodes 5–7 behave as NOP and set `err`.
- Config commands (SET_POS, SET_TYPE, CLEAR_POS, NOP) complete in the accept cycle; the FSM stays in IDLE.
- ENCRYPT:
  - `cmd_data` > 25 sets `err`; the command is dropped and the FSM stays in IDLE.
  - Otherwise the char is latched into `dp_char` and the FSM goes IDLE→STEP.
- STEP, with notch flags evaluated on the pre-step positions:
  - The right rotor always steps.
  - The middle rotor steps if the right rotor is at its notch OR the middle rotor is at its own notch (double-step).
  - The left rotor steps if the middle rotor is at its notch.
  - All steps are mod 26 (25→0).
  - STEP→XLATE.
- XLATE: pulse `dp_start`, go to WAIT.
- WAIT:
  - On `dp_done`, capture `dp_result` and go to EMIT.
  - If `DP_TIMEOUT` cycles pass without `dp_done`, set `err` and return to IDLE with no `out_valid`. The rotor steps already taken are kept.
- EMIT: `out_valid`=1, go to IDLE.
- `dp_done` outside WAIT is ignored.
- Notch letters per type: 0:I=16 (Q), 1:II=4 (E), 2:III=21 (V), 3:IV=9 (J), 4:V=25 (Z).

## Timing
- Reset values: FSM=IDLE, all positions=0, types={0,1,2} (left=I, mid=II, right=III), `li`=`ti`=0, `cmd_ready`=1, `busy`=0, `dp_start`=0, `dp_char`=0, `out_valid`=0, `out_char`=0, `err`=0.
- `rst` has priority in any state. An encryption in flight is abandoned: no `out_valid` is produced and `dp_start` is not asserted after reset.
- ENCRYPT accepted at cycle T:
  - `pos` shows the stepped value at T+2.
  - `dp_start` pulses at T+2.
  - `dp_done` is sampled from T+3 onward.
  - `out_valid` is asserted the cycle after `dp_done` is seen.
  - Minimum latency is T+4 with a datapath that returns `dp_done` one cycle after `dp_start`.
- `cmd_ready` is low from T+1 until EMIT completes. It returns high in the cycle after the `out_valid` cycle, so ENCRYPTs can be issued back-to-back every 5 cycles with a 1-cycle datapath.
- `pos` changes only in STEP or on a config command. It never changes during WAIT.

## Structure
- `enigma_pkg` holds:
  - `N_LETTERS`=26.
  - The opcode constants.
  - The rotor-type enum.
  - A notch lookup function mapping type to notch letter.
  - The FSM state enum.
- Sub-module `rotor_pos_counter`, one instance per rotor:
  - mod-26 register with `load`, `load_val`, `step`, `clr` inputs.
  - Combinational `at_notch` output derived from its type input.
- The FSM, the `li`/`ti` indices, `err` and the timeout counter live in `enigma_step_ctrl`.

## Test plan
- Reset, then SET_TYPE ×3 = {III, II, I} (right first), SET_POS ×3 = {21, 3, 0}, then ENCRYPT 0 -> `pos` goes from {0,3,21} to {0,4,22} (ADV→AEW); a second ENCRYPT -> {1,5,23} (double-step, AEW→BFX).
- Positions {0,0,25}, right rotor type V, ENCRYPT -> right wraps 25→0 and the middle steps to 1; `out_valid` appears exactly 4 cycles after accept with a 1-cycle datapath model.
- Datapath model delaying `dp_done` by 5 cycles -> `cmd_ready` stays low throughout, a `cmd_valid` held during that time is not accepted, and `out_char` equals the model's `dp_result`.
- SET_POS with data 27, ENCRYPT with data 30, and opcode 6 -> `err`=1, positions unchanged, no `dp_start`; a following CLEAR_POS -> `err`=0 and all positions 0.
- Datapath model that never asserts `dp_done` -> `err`=1 after `DP_TIMEOUT` cycles, FSM back in IDLE, no `out_valid`.
- `rst` asserted during WAIT -> next cycle all outputs are at reset values; a late `dp_done` produces no `out_valid`.

Source files
------------

// File: rtl/enigma_pkg.sv
// Shared constants, enums and the notch table for the Enigma stepping controller.
package enigma_pkg;

  localparam int N_LETTERS = 26;
  localparam logic [4:0] LAST_LETTER = 5'(N_LETTERS - 1);

  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_SET_POS   = 3'd1;
  localparam logic [2:0] OP_SET_TYPE  = 3'd2;
  localparam logic [2:0] OP_ENCRYPT   = 3'd3;
  localparam logic [2:0] OP_CLEAR_POS = 3'd4;

  typedef enum logic [2:0] {
    ROT_I   = 3'd0,
    ROT_II  = 3'd1,
    ROT_III = 3'd2,
    ROT_IV  = 3'd3,
    ROT_V   = 3'd4
  } rotor_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STEP,
    ST_XLATE,
    ST_WAIT,
    ST_EMIT
  } state_t;

  function automatic logic [4:0] notch_of(input logic [2:0] t);
    case (t)
      ROT_I:   return 5'd16;
      ROT_II:  return 5'd4;
      ROT_III: return 5'd21;
      ROT_IV:  return 5'd9;
      ROT_V:   return 5'd25;
      default: return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/rotor_pos_counter.sv
// One rotor position: mod-26 counter with load/step/clear and a notch detector.
module rotor_pos_counter
  import enigma_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       load,
  input  logic [4:0] load_val,
  input  logic       step,
  input  logic [2:0] rtype,
  output logic [4:0] pos,
  output logic       at_notch
);

  logic [4:0] r_pos;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_pos <= '0;
    end else if (load) begin
      r_pos <= load_val;
    end else if (step) begin
      r_pos <= (r_pos == LAST_LETTER) ? 5'd0 : r_pos + 5'd1;
    end
  end

  assign pos      = r_pos;
  assign at_notch = (r_pos == notch_of(rtype));

endmodule

// File: rtl/enigma_step_ctrl.sv
// Command decoder and stepping sequencer: owns rotor positions/types and runs
// the datapath start/done handshake for each ENCRYPT.
module enigma_step_ctrl
  import enigma_pkg::*;
#(
  parameter int N_ROT      = 3,
  parameter int DP_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [4:0]         cmd_data,
  output logic [N_ROT*5-1:0] pos,
  output logic [N_ROT*3-1:0] rot_type,
  output logic               dp_start,
  output logic [4:0]         dp_char,
  input  logic               dp_done,
  input  logic [4:0]         dp_result,
  output logic               out_valid,
  output logic [4:0]         out_char,
  output logic               busy,
  output logic               err
);

  localparam int IDX_W = (N_ROT > 1) ? $clog2(N_ROT) : 1;
  localparam int TO_W  = $clog2(DP_TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ROT - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(DP_TIMEOUT - 1);

  state_t                 r_state, w_next;
  logic [IDX_W-1:0]       r_li, r_ti;
  logic [N_ROT-1:0][2:0]  r_types;
  logic [4:0]             r_dp_char, r_out_char;
  logic [TO_W-1:0]        r_to_cnt;
  logic                   r_err;

  logic w_accept, w_letter_ok, w_type_ok, w_in_step, w_timeout;
  logic w_do_pos, w_do_type, w_do_clr, w_do_enc, w_cmd_err;
  logic [N_ROT-1:0][4:0]  w_pos;
  logic [N_ROT-1:0]       w_notch, w_load, w_step;

  assign w_accept    = cmd_valid && (r_state == ST_IDLE);
  assign w_letter_ok = (cmd_data <= LAST_LETTER);
  assign w_type_ok   = (cmd_data <= {2'b00, ROT_V});
  assign w_do_pos    = w_accept && (cmd_op == OP_SET_POS) && w_letter_ok;
  assign w_do_type   = w_accept && (cmd_op == OP_SET_TYPE) && w_type_ok;
  assign w_do_clr    = w_accept && (cmd_op == OP_CLEAR_POS);
  assign w_do_enc    = w_accept && (cmd_op == OP_ENCRYPT) && w_letter_ok;
  assign w_cmd_err   = w_accept &&
                       ((((cmd_op == OP_SET_POS) || (cmd_op == OP_ENCRYPT)) && !w_letter_ok) ||
                        ((cmd_op == OP_SET_TYPE) && !w_type_ok) ||
                        (cmd_op > OP_CLEAR_POS));
  assign w_in_step   = (r_state == ST_STEP);

  // Notch flags come from the pre-step positions; the leftmost rotor has no double-step.
  for (genvar g = 0; g < N_ROT; g++) begin : g_rot
    assign w_load[g] = w_do_pos && (r_li == IDX_W'(g));
    if (g == 0) begin : g_fast
      assign w_step[g] = w_in_step;
    end else begin : g_slow
      localparam bit DOUBLE = (g < N_ROT - 1);
      assign w_step[g] = w_in_step && (w_notch[g-1] || (DOUBLE && w_notch[g]));
    end
    rotor_pos_counter u_rot (
      .clk      (clk),
      .rst      (rst),
      .clr      (w_do_clr),
      .load     (w_load[g]),
      .load_val (cmd_data),
      .step     (w_step[g]),
      .rtype    (r_types[g]),
      .pos      (w_pos[g]),
      .at_notch (w_notch[g])
    );
  end

  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    unique case (r_state)
      ST_IDLE:  if (w_do_enc) w_next = ST_STEP;
      ST_STEP:  w_next = ST_XLATE;
      ST_XLATE: w_next = ST_WAIT;
      ST_WAIT: begin
        if (dp_done) begin
          w_next = ST_EMIT;
        end else if (r_to_cnt == TO_LAST) begin
          w_timeout = 1'b1;
          w_next    = ST_IDLE;
        end
      end
      ST_EMIT:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_li       <= '0;
      r_ti       <= '0;
      r_err      <= 1'b0;
      r_dp_char  <= '0;
      r_out_char <= '0;
      r_to_cnt   <= '0;
      for (int i = 0; i < N_ROT; i++) r_types[i] <= 3'(N_ROT - 1 - i);
    end else begin
      r_state <= w_next;
      if (w_do_clr) begin
        r_li  <= '0;
        r_ti  <= '0;
        r_err <= 1'b0;
      end else begin
        if (w_cmd_err || w_timeout) r_err <= 1'b1;
        if (w_do_pos) r_li <= (r_li == LAST_IDX) ? '0 : r_li + IDX_W'(1);
        if (w_do_type) begin
          r_types[r_ti] <= cmd_data[2:0];
          r_ti          <= (r_ti == LAST_IDX) ? '0 : r_ti + IDX_W'(1);
        end
      end
      if (w_do_enc) r_dp_char <= cmd_data;
      if ((r_state == ST_WAIT) && dp_done) r_out_char <= dp_result;
      r_to_cnt <= (r_state == ST_WAIT) ? r_to_cnt + TO_W'(1) : '0;
    end
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = ~cmd_ready;
  assign pos       = w_pos;
  assign rot_type  = r_types;
  assign dp_start  = (r_state == ST_XLATE);
  assign dp_char   = r_dp_char;
  assign out_valid = (r_state == ST_EMIT);
  assign out_char  = r_out_char;
  assign err       = r_err;

endmodule
